midi_voice_allocator: RTL and testbench
=======================================

# midi_voice_allocator

Polyphonic MIDI front end: consumes decoded MIDI bytes from the UART receiver and drives NUM_VOICES independent voices, each with its own note, velocity, gate and trigger. It is the parametrised successor to the single-voice MIDI player. It sits between the serial byte receiver and the per-voice oscillator/ADSR/mixer chain that feeds the PDM DAC. Adds running status, channel filtering, note retrigger, oldest-voice stealing and all-notes-off.

## Interface
- NUM_VOICES, 4, number of voices (2..16)
- MIDI_CHANNEL, 0, channel to respond to (0..15)
- OMNI, 0, 1 = respond to all channels
- clk  input  1  system clock
- rst_n  input  1  reset, synchronous, active-low
- byte_in  input  8  received MIDI byte
- byte_valid  input  1  one-cycle strobe, byte_in valid; may be high every cycle
- voice_note  output  7*NUM_VOICES  note number, voice v at [7v+6:7v]
- voice_velocity  output  7*NUM_VOICES  velocity, same packing
- voice_gate  output  NUM_VOICES  high while note held
- voice_trig  output  NUM_VOICES  one-cycle pulse on (re)trigger

## Operation
- Reset values: all gates, trigs, notes and velocities 0; parser IDLE; running status cleared; age[v]=v.
- Bytes with byte_valid low are ignored.
- Parser states: IDLE, DATA1, DATA2.
  - 0xF8–0xFF (real-time): ignored; state and running status unchanged.
  - 0xF0–0xF7: clear running status, go IDLE; data bytes that follow are dropped until the next channel status byte.
  - 0x80–0xEF: latch as running status, go DATA1. Any partial message is abandoned.
  - Data byte (bit7=0) in IDLE: with running status held, treat as DATA1 byte; otherwise drop.
  - DATA1: latch d1. Types 0xC/0xD complete here and go IDLE; all others go DATA2.
  - DATA2: latch d2, message complete, go IDLE.
- Completed messages whose channel mismatches (OMNI=0) are discarded; bytes are still consumed so running status stays aligned.
- Note on (0x9n, d2≠0):
  - Priority 1: a voice with gate=1 and note=d1 exists. Retrigger the lowest such voice with velocity d2 and pulse its trig.
  - Priority 2: otherwise use the lowest-index voice with gate=0.
  - Priority 3: otherwise steal the voice with age==NUM_VOICES-1.
  - Allocated voice: note=d1, velocity=d2, gate=1, trig pulse.
  - Ages: allocated voice becomes 0; every voice whose age was below its old age increments. Ages always remain a permutation of 0..NUM_VOICES-1.
  - A retrigger updates ages the same way.
- Note off (0x8n, or 0x9n with d2=0): every voice with gate=1 and note=d1 drops gate. Note and velocity are retained so the release phase sounds. Ages are unchanged. A note-off for an unheld note has no effect.
- Control change 0xBn with d1=120 or 123: all gates to 0. Other controllers, program change, aftertouch and pitch bend are consumed and ignored.

## Timing
- Two stages. The edge sampling the final byte registers a decoded event (type, note, velocity). The next edge applies it to the voice state.
- Outputs change exactly 1 cycle after the edge that sampled the completing byte.
- A trig is high for exactly that one cycle.
- Minimum event spacing is 2 bytes, i.e. 2 cycles at full rate, so the event stage never overflows. Back-to-back running-status events at byte_valid=1 every cycle must all be applied in order.
- Allocation search is combinational on the current voice state. An event always sees the effects of the previous event.
- A real-time byte between data bytes adds one cycle of latency and nothing else.
- rst_n low on any edge overrides everything: a pending event is discarded and outputs return to reset values on that edge.

## Test plan
- 90 3C 64 with NUM_VOICES=4: one cycle after the edge sampling 64, voice0 note=0x3C, vel=0x64, gate=1, and trig0 pulses for 1 cycle. 80 3C 00 then drops gate0; note0 stays 0x3C.
- Running status: 90 3C 40, 3E 40, 40 40, 43 40, 45 50 streamed at byte_valid every cycle. Voices 0–3 get 3C, 3E, 40, 43. 45 steals voice0 (oldest), giving note0=0x45, vel0=0x50, trig0 pulse.
- 90 3C 40 then 90 3C 7F: voice0 retriggered with vel=0x7F and trig0 pulse; voice1 stays idle. 90 3C 00 then releases voice0.
- MIDI_CHANNEL=0, OMNI=0: 91 3C 40 causes no change. F8 inserted between 3C and 40 of 90 3C 40 still yields voice0 on.
- Four notes held, then B0 7B 00: all gates 0 one cycle later with no trig pulses. F0 3C 40 afterwards causes no change.
- rst_n low for 1 cycle between the data bytes of 90 3C | 40: all outputs reset. A following 40 is dropped because running status was cleared.

Source files
------------

// File: rtl/midi_voice_allocator.sv
// midi_voice_allocator: polyphonic MIDI parser and voice allocator.
//
// Turns a stream of received MIDI bytes into NUM_VOICES voices, each with a
// note, velocity, gate and one-cycle trigger. Handles running status, channel
// filtering, retrigger of a held note, stealing the oldest voice, and
// all-notes-off.
//
// Ports:
//   clk            system clock
//   rst_n          synchronous active-low reset
//   byte_in        received MIDI byte
//   byte_valid     one-cycle strobe qualifying byte_in
//   voice_note     note number per voice, voice v at [7v+6:7v]
//   voice_velocity velocity per voice, same packing
//   voice_gate     high while the voice's note is held
//   voice_trig     one-cycle pulse when a voice is (re)triggered
module midi_voice_allocator #(
   parameter int NUM_VOICES   = 4,
   parameter int MIDI_CHANNEL = 0,
   parameter bit OMNI         = 1'b0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [7:0]              byte_in,
   input  logic                    byte_valid,
   output logic [7*NUM_VOICES-1:0] voice_note,
   output logic [7*NUM_VOICES-1:0] voice_velocity,
   output logic [NUM_VOICES-1:0]   voice_gate,
   output logic [NUM_VOICES-1:0]   voice_trig
);
   localparam int AW = $clog2(NUM_VOICES);
   localparam logic [3:0] CH = 4'(MIDI_CHANNEL);

   typedef enum logic [1:0] {IDLE, DATA1, DATA2} st_t;
   typedef enum logic [1:0] {EV_ON, EV_OFF, EV_ALL} ev_t;

   st_t st_q, st_d;
   logic [7:0] rs_q, rs_d;
   logic rs_v_q, rs_v_d;
   logic [6:0] d1_q, d1_d;
   logic ev_valid_q, ev_valid_d;
   ev_t ev_type_q, ev_type_d;
   logic [6:0] ev_note_q, ev_note_d;
   logic [6:0] ev_vel_q, ev_vel_d;

   logic [NUM_VOICES-1:0][6:0] note_q, note_d;
   logic [NUM_VOICES-1:0][6:0] vel_q, vel_d;
   logic [NUM_VOICES-1:0] gate_q, gate_d;
   logic [NUM_VOICES-1:0] trig_q, trig_d;
   logic [NUM_VOICES-1:0][AW-1:0] age_q, age_d;

   logic ch_ok;
   logic hit, free;
   logic [AW-1:0] hit_idx, free_idx, old_idx, sel;

   assign ch_ok = OMNI || (rs_q[3:0] == CH);

   // Byte parser: the edge sampling a message's final byte registers one event.
   always_comb begin
      st_d       = st_q;
      rs_d       = rs_q;
      rs_v_d     = rs_v_q;
      d1_d       = d1_q;
      ev_valid_d = 1'b0;
      ev_type_d  = ev_type_q;
      ev_note_d  = ev_note_q;
      ev_vel_d   = ev_vel_q;
      if (byte_valid) begin
         if (byte_in[7:3] == 5'b11111) begin
            // real-time bytes are transparent to the parser
         end else if (byte_in[7:4] == 4'hF) begin
            rs_v_d = 1'b0;
            st_d   = IDLE;
         end else if (byte_in[7]) begin
            rs_d   = byte_in;
            rs_v_d = 1'b1;
            st_d   = DATA1;
         end else if (st_q == DATA2) begin
            st_d      = IDLE;
            ev_note_d = d1_q;
            ev_vel_d  = byte_in[6:0];
            // note-on with zero velocity is a note-off
            if (ch_ok && rs_q[7:4] == 4'h9) begin
               ev_valid_d = 1'b1;
               ev_type_d  = (byte_in[6:0] != 7'd0) ? EV_ON : EV_OFF;
            end else if (ch_ok && rs_q[7:4] == 4'h8) begin
               ev_valid_d = 1'b1;
               ev_type_d  = EV_OFF;
            end else if (ch_ok && rs_q[7:4] == 4'hB && (d1_q == 7'd120 || d1_q == 7'd123)) begin
               ev_valid_d = 1'b1;
               ev_type_d  = EV_ALL;
            end
         end else if (st_q == DATA1 || rs_v_q) begin
            // program change and channel pressure carry a single data byte
            d1_d = byte_in[6:0];
            st_d = (rs_q[7:4] == 4'hC || rs_q[7:4] == 4'hD) ? IDLE : DATA2;
         end
      end
   end

   // Voice stage: applies the registered event to the current voice state.
   always_comb begin
      note_d   = note_q;
      vel_d    = vel_q;
      gate_d   = gate_q;
      age_d    = age_q;
      trig_d   = '0;
      hit      = 1'b0;
      free     = 1'b0;
      hit_idx  = '0;
      free_idx = '0;
      old_idx  = '0;
      // scanning downward leaves the lowest matching index in each result
      for (int v = NUM_VOICES - 1; v >= 0; v--) begin
         if (gate_q[v] && note_q[v] == ev_note_q) begin
            hit     = 1'b1;
            hit_idx = AW'(v);
         end
         if (!gate_q[v]) begin
            free     = 1'b1;
            free_idx = AW'(v);
         end
         if (age_q[v] == AW'(NUM_VOICES - 1)) old_idx = AW'(v);
      end
      sel = hit ? hit_idx : free ? free_idx : old_idx;
      if (ev_valid_q && ev_type_q == EV_ON) begin
         note_d[sel] = ev_note_q;
         vel_d[sel]  = ev_vel_q;
         gate_d[sel] = 1'b1;
         trig_d[sel] = 1'b1;
         // ages stay a permutation: the chosen voice becomes youngest and
         // every voice younger than it moves up by one
         for (int v = 0; v < NUM_VOICES; v++)
            age_d[v] = (AW'(v) == sel) ? '0 : (age_q[v] < age_q[sel]) ? age_q[v] + 1'b1 : age_q[v];
      end else if (ev_valid_q) begin
         for (int v = 0; v < NUM_VOICES; v++)
            gate_d[v] = gate_q[v] && !(ev_type_q == EV_ALL || note_q[v] == ev_note_q);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st_q       <= IDLE;
         rs_q       <= '0;
         rs_v_q     <= 1'b0;
         d1_q       <= '0;
         ev_valid_q <= 1'b0;
         ev_type_q  <= EV_ON;
         ev_note_q  <= '0;
         ev_vel_q   <= '0;
         note_q     <= '0;
         vel_q      <= '0;
         gate_q     <= '0;
         trig_q     <= '0;
         for (int v = 0; v < NUM_VOICES; v++) age_q[v] <= AW'(v);
      end else begin
         st_q       <= st_d;
         rs_q       <= rs_d;
         rs_v_q     <= rs_v_d;
         d1_q       <= d1_d;
         ev_valid_q <= ev_valid_d;
         ev_type_q  <= ev_type_d;
         ev_note_q  <= ev_note_d;
         ev_vel_q   <= ev_vel_d;
         note_q     <= note_d;
         vel_q      <= vel_d;
         gate_q     <= gate_d;
         trig_q     <= trig_d;
         age_q      <= age_d;
      end
   end

   assign voice_note     = note_q;
   assign voice_velocity = vel_q;
   assign voice_gate     = gate_q;
   assign voice_trig     = trig_q;
endmodule

// File: tb/tb_midi_voice_allocator.sv
// tb_midi_voice_allocator: directed and random checks against a byte-level model.
module tb_midi_voice_allocator;
   localparam int N  = 4;
   localparam int CH = 0;
   localparam bit OM = 1'b0;
   localparam int IDL = -1;
   localparam int RST = -2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [7:0] byte_in = 8'h00;
   logic byte_valid = 1'b0;
   logic [7*N-1:0] voice_note, voice_velocity;
   logic [N-1:0] voice_gate, voice_trig;

   int vectors = 0;
   int errors  = 0;

   midi_voice_allocator #(.NUM_VOICES(N), .MIDI_CHANNEL(CH), .OMNI(OM)) dut (
      .clk(clk), .rst_n(rst_n), .byte_in(byte_in), .byte_valid(byte_valid),
      .voice_note(voice_note), .voice_velocity(voice_velocity),
      .voice_gate(voice_gate), .voice_trig(voice_trig)
   );

   always #5 clk = ~clk;

   // Model: voices plus a recency list (front = most recently allocated).
   int m_note[N], m_vel[N];
   bit m_gate[N], m_trig[N];
   int lru[$];
   int m_rs, m_phase, m_d1;
   bit p_v;
   int p_kind, p_n, p_vel;

   function automatic void m_reset();
      for (int i = 0; i < N; i++) begin
         m_note[i] = 0; m_vel[i] = 0; m_gate[i] = 0; m_trig[i] = 0;
      end
      lru = {};
      for (int i = 0; i < N; i++) lru.push_back(i);
      m_rs = -1; m_phase = 0; m_d1 = 0; p_v = 0;
   endfunction

   function automatic void m_apply();
      int sel = -1;
      if (p_kind == 1) begin
         for (int i = 0; i < N && sel < 0; i++) if (m_gate[i] && m_note[i] == p_n) sel = i;
         for (int i = 0; i < N && sel < 0; i++) if (!m_gate[i]) sel = i;
         if (sel < 0) sel = lru[lru.size() - 1];
         m_note[sel] = p_n; m_vel[sel] = p_vel; m_gate[sel] = 1; m_trig[sel] = 1;
         for (int i = 0; i < lru.size(); i++) if (lru[i] == sel) begin lru.delete(i); break; end
         lru.push_front(sel);
      end else begin
         for (int i = 0; i < N; i++) if (p_kind == 3 || m_note[i] == p_n) m_gate[i] = 0;
      end
   endfunction

   function automatic void m_byte(int b);
      int t;
      if (b >= 'hF8) return;
      if (b >= 'hF0) begin m_rs = -1; m_phase = 0; return; end
      if (b >= 'h80) begin m_rs = b; m_phase = 1; return; end
      if (m_rs < 0) return;
      t = m_rs / 16;
      if (m_phase != 2) begin m_d1 = b; m_phase = (t == 12 || t == 13) ? 0 : 2; return; end
      m_phase = 0;
      if (!OM && (m_rs % 16) != CH) return;
      p_n = m_d1; p_vel = b;
      if (t == 9) begin p_v = 1; p_kind = (b != 0) ? 1 : 2; end
      else if (t == 8) begin p_v = 1; p_kind = 2; end
      else if (t == 11 && (m_d1 == 120 || m_d1 == 123)) begin p_v = 1; p_kind = 3; end
   endfunction

   function automatic void m_edge(int b, bit v, bit r);
      if (!r) begin m_reset(); return; end
      for (int i = 0; i < N; i++) m_trig[i] = 0;
      if (p_v) begin m_apply(); p_v = 0; end
      if (v) m_byte(b);
   endfunction

   function automatic logic [16*N-1:0] exp_vec();
      logic [7*N-1:0] n, ve;
      logic [N-1:0] g, t;
      for (int i = 0; i < N; i++) begin
         n[7*i+:7] = 7'(m_note[i]); ve[7*i+:7] = 7'(m_vel[i]);
         g[i] = m_gate[i]; t[i] = m_trig[i];
      end
      return {n, ve, g, t};
   endfunction

   function automatic logic [16*N-1:0] dut_vec();
      return {voice_note, voice_velocity, voice_gate, voice_trig};
   endfunction

   task automatic step(input int b, input bit v, input bit r);
      byte_in = 8'(b); byte_valid = v; rst_n = r;
      @(posedge clk);
      m_edge(b, v, r);
      #1;
   endtask

   task automatic feed(input int x);
      if (x == RST) step(0, 0, 0);
      else if (x == IDL) step(0, 0, 1);
      else step(x, 1, 1);
   endtask

   task automatic test_reset();
      step(8'h90, 1, 0);
      step(8'h3C, 1, 0);
      vectors++;
      if (dut_vec() !== exp_vec() || voice_gate !== '0 || voice_note !== '0) begin
         errors++; $display("FAIL reset: got %h expected %h", dut_vec(), exp_vec());
      end
   endtask

   task automatic test_basic();
      int s1[] = '{RST, 'h90, 'h3C, 'h64, IDL};
      int s2[] = '{IDL, 'h80, 'h3C, 'h00, IDL, IDL};
      foreach (s1[i]) begin
         feed(s1[i]); vectors++;
         if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL basic_on[%0d]: got %h expected %h", i, dut_vec(), exp_vec()); end
      end
      vectors++;
      if (voice_note[6:0] !== 7'h3C || voice_velocity[6:0] !== 7'h64 || voice_gate !== 4'b0001 || voice_trig !== 4'b0001) begin
         errors++; $display("FAIL basic_const_on: got %h expected note 3c vel 64 gate 1 trig 1", dut_vec());
      end
      foreach (s2[i]) begin
         feed(s2[i]); vectors++;
         if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL basic_off[%0d]: got %h expected %h", i, dut_vec(), exp_vec()); end
      end
      vectors++;
      if (voice_gate !== 4'b0000 || voice_note[6:0] !== 7'h3C || voice_trig !== 4'b0000) begin
         errors++; $display("FAIL basic_const_off: got %h expected gate 0 note0 3c", dut_vec());
      end
   endtask

   task automatic test_back_to_back();
      int s[] = '{RST, 'h90, 'h3C, 'h40, 'h3E, 'h40, 'h40, 'h40, 'h43, 'h40, 'h45, 'h50, IDL, IDL};
      foreach (s[i]) begin
         feed(s[i]); vectors++;
         if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL b2b[%0d]: got %h expected %h", i, dut_vec(), exp_vec()); end
      end
      vectors++;
      if (voice_note !== {7'h43, 7'h40, 7'h3E, 7'h45} || voice_velocity[6:0] !== 7'h50 || voice_gate !== 4'b1111) begin
         errors++; $display("FAIL b2b_const: got %h expected notes 43 40 3e 45 vel0 50 gate f", dut_vec());
      end
   endtask

   task automatic test_retrigger();
      int s[] = '{RST, 'h90, 'h3C, 'h40, 'h90, 'h3C, 'h7F, IDL};
      int s2[] = '{'h90, 'h3C, 'h00, IDL, IDL};
      foreach (s[i]) begin
         feed(s[i]); vectors++;
         if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL retrig[%0d]: got %h expected %h", i, dut_vec(), exp_vec()); end
      end
      vectors++;
      if (voice_gate !== 4'b0001 || voice_velocity[6:0] !== 7'h7F || voice_trig !== 4'b0001) begin
         errors++; $display("FAIL retrig_const: got %h expected gate 1 vel0 7f trig 1", dut_vec());
      end
      foreach (s2[i]) begin
         feed(s2[i]); vectors++;
         if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL retrig_off[%0d]: got %h expected %h", i, dut_vec(), exp_vec()); end
      end
      vectors++;
      if (voice_gate !== 4'b0000) begin errors++; $display("FAIL retrig_release: got gate %b expected 0000", voice_gate); end
   endtask

   task automatic test_channel_realtime();
      int s[] = '{RST, 'h91, 'h3C, 'h40, IDL, IDL, 'h90, 'h3C, 'hF8, 'h40, IDL, IDL};
      foreach (s[i]) begin
         feed(s[i]); vectors++;
         if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL chan_rt[%0d]: got %h expected %h", i, dut_vec(), exp_vec()); end
      end
      vectors++;
      if (voice_gate !== 4'b0001 || voice_note[6:0] !== 7'h3C) begin
         errors++; $display("FAIL chan_rt_const: got %h expected gate 0001 note0 3c", dut_vec());
      end
   endtask

   task automatic test_all_off();
      int s[] = '{RST, 'h90, 'h3C, 'h40, 'h3E, 'h40, 'h40, 'h40, 'h43, 'h40, IDL,
                  'hB0, 'h7B, 'h00, IDL, 'hF0, 'h3C, 'h40, IDL, IDL};
      foreach (s[i]) begin
         feed(s[i]); vectors++;
         if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL all_off[%0d]: got %h expected %h", i, dut_vec(), exp_vec()); end
      end
      vectors++;
      if (voice_gate !== 4'b0000 || voice_trig !== 4'b0000 || voice_note[27:21] !== 7'h43) begin
         errors++; $display("FAIL all_off_const: got %h expected gates 0 note3 43", dut_vec());
      end
   endtask

   task automatic test_reset_mid();
      int s[] = '{RST, 'h90, 'h3C, RST, 'h40, IDL, IDL};
      foreach (s[i]) begin
         feed(s[i]); vectors++;
         if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL reset_mid[%0d]: got %h expected %h", i, dut_vec(), exp_vec()); end
      end
      vectors++;
      if (dut_vec() !== '0) begin errors++; $display("FAIL reset_mid_const: got %h expected 0", dut_vec()); end
   endtask

   task automatic test_random();
      int st[] = '{'h90, 'h90, 'h90, 'h80, 'h91, 'hB0, 'hC0, 'hD0, 'hE0, 'hF8, 'hF0, 'h9F};
      int b, r;
      feed(RST);
      for (int i = 0; i < 3000; i++) begin
         r = $urandom_range(0, 99);
         if (r < 2) begin feed(RST); end
         else if (r < 15) begin feed(IDL); end
         else begin
            r = $urandom_range(0, 99);
            if (r < 20) b = st[$urandom_range(0, st.size() - 1)];
            else if (r < 25) b = ($urandom_range(0, 1) != 0) ? 123 : 120;
            else if (r < 35) b = 0;
            else b = 'h3C + $urandom_range(0, 7);
            feed(b);
         end
         vectors++;
         if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL random[%0d]: got %h expected %h", i, dut_vec(), exp_vec()); end
      end
   endtask

   initial begin
      m_reset();
      test_reset();
      test_basic();
      test_back_to_back();
      test_retrigger();
      test_channel_realtime();
      test_all_off();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
